// File: rtl/calc_engine_n_pkg.sv
// Shared command/response encodings and the request-FIFO entry layout for calc_engine_n.
// Entry fields are sized for the widest supported operand and tag; narrower instances zero-pad.
package calc_engine_n_pkg;
    localparam int CMD_W      = 4;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_TAG_W  = 8;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_SHL  = 4'd5,
        CMD_SHR  = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_OK   = 2'b01,
        RESP_ERR  = 2'b10
    } resp_e;

    typedef struct packed {
        logic [CMD_W-1:0]      cmd;
        logic [MAX_TAG_W-1:0]  tag;
        logic [MAX_DATA_W-1:0] op1;
        logic [MAX_DATA_W-1:0] op2;
    } req_entry_t;
endpackage

// File: rtl/calc_req_fifo.sv
// Per-port request FIFO: circular buffer with occupancy count; storage has no reset.
module calc_req_fifo
    import calc_engine_n_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(req_entry_t)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
endmodule

// File: rtl/calc_engine_n.sv
// Multi-port calculator: two-beat requests queue per port, a round-robin arbiter feeds one
// shared execute register, and each result is presented on its port for a single cycle.
module calc_engine_n
    import calc_engine_n_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
    input  logic [TAG_W*NUM_PORTS-1:0]  req_tag_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [2*NUM_PORTS-1:0]      out_resp,
    output logic [DATA_W*NUM_PORTS-1:0] out_data,
    output logic [TAG_W*NUM_PORTS-1:0]  out_tag
);
    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int SHW = $clog2(DATA_W);
    localparam int EW  = $bits(req_entry_t);

    function automatic logic [DATA_W+1:0] execute(input logic [3:0] cmd,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] d;
        resp_e             r;
        sum = {1'b0, a} + {1'b0, b};
        d   = '0;
        r   = RESP_ERR;
        case (cmd)
            CMD_ADD: if (!sum[DATA_W]) begin r = RESP_OK; d = sum[DATA_W-1:0]; end
            CMD_SUB: if (b <= a) begin r = RESP_OK; d = a - b; end
            CMD_SHL: begin r = RESP_OK; d = a << b[SHW-1:0]; end
            CMD_SHR: begin r = RESP_OK; d = a >> b[SHW-1:0]; end
            default: ;
        endcase
        return {r, d};
    endfunction

    logic                 en_q;
    logic [NUM_PORTS-1:0] pend, empty, pop;
    logic [CW-1:0]        count    [NUM_PORTS];
    logic [EW-1:0]        rd_entry [NUM_PORTS];

    // Stage 0: operand1 capture, operand2 merge and FIFO write per port
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic              pend_q;
        logic [3:0]        cap_cmd_q;
        logic [TAG_W-1:0]  cap_tag_q;
        logic [DATA_W-1:0] cap_op1_q;
        logic              accept;
        req_entry_t        wr_entry;

        assign req_ready[p] = en_q & ~pend_q &
                              ((count[p] + CW'(pend_q)) < CW'(FIFO_DEPTH));
        assign accept  = req_ready[p] & (req_cmd_in[p*4 +: 4] != 4'd0);
        assign pend[p] = pend_q;

        always_ff @(posedge clk) begin
            if (reset) pend_q <= 1'b0;
            else       pend_q <= accept;
        end

        always_ff @(posedge clk) begin
            if (accept) begin
                cap_cmd_q <= req_cmd_in[p*4 +: 4];
                cap_tag_q <= req_tag_in[p*TAG_W +: TAG_W];
                cap_op1_q <= req_data_in[p*DATA_W +: DATA_W];
            end
        end

        always_comb begin
            wr_entry                    = '0;
            wr_entry.cmd                = cap_cmd_q;
            wr_entry.tag[TAG_W-1:0]     = cap_tag_q;
            wr_entry.op1[DATA_W-1:0]    = cap_op1_q;
            wr_entry.op2[DATA_W-1:0]    = req_data_in[p*DATA_W +: DATA_W];
        end

        calc_req_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (pend_q),
            .wr_data_i (wr_entry),
            .rd_en_i   (pop[p]),
            .rd_data_o (rd_entry[p]),
            .empty_o   (empty[p]),
            .count_o   (count[p])
        );
    end

    // Stage 1: round-robin grant loads the shared execute register
    logic [PW-1:0] last_q, grant_idx;
    logic          grant_vld;
    int            idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        pop       = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(last_q) + i) % NUM_PORTS;
            if (!grant_vld && !empty[PW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(idx);
            end
        end
        if (grant_vld) pop[grant_idx] = 1'b1;
    end

    logic          exe_vld_q;
    logic [PW-1:0] exe_port_q;
    req_entry_t    exe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            exe_vld_q <= 1'b0;
            last_q    <= PW'(NUM_PORTS - 1);
        end else begin
            en_q      <= 1'b1;
            exe_vld_q <= grant_vld;
            if (grant_vld) last_q <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_vld) begin
            exe_port_q <= grant_idx;
            exe_q      <= rd_entry[grant_idx];
        end
    end

    // Stage 2: result registered onto the owning port for one cycle
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_data;
    logic              unused_pad;

    assign {res_resp, res_data} = execute(exe_q.cmd, exe_q.op1[DATA_W-1:0], exe_q.op2[DATA_W-1:0]);
    assign unused_pad = ^{exe_q.tag, exe_q.op1, exe_q.op2};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            if (exe_vld_q) begin
                out_resp[exe_port_q*2 +: 2]          <= res_resp;
                out_data[exe_port_q*DATA_W +: DATA_W] <= res_data;
                out_tag[exe_port_q*TAG_W +: TAG_W]    <= exe_q.tag[TAG_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_calc_engine_n.sv
// Bench for calc_engine_n: directed scenarios plus random traffic against a queue-based model.
module tb_calc_engine_n;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [4*NP-1:0]   req_cmd_in;
    logic [TW*NP-1:0]  req_tag_in;
    logic [DW*NP-1:0]  req_data_in;
    logic [NP-1:0]     req_ready;
    logic [2*NP-1:0]   out_resp;
    logic [DW*NP-1:0]  out_data;
    logic [TW*NP-1:0]  out_tag;

    calc_engine_n #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_tag_in  (req_tag_in),
        .req_data_in (req_data_in),
        .req_ready   (req_ready),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    typedef struct {
        int unsigned     cmd;
        int unsigned     tag;
        longint unsigned a;
        longint unsigned b;
    } job_t;

    job_t        q [NP][$];
    bit          m_pend [NP];
    job_t        m_cap  [NP];
    bit          m_en;
    int          m_last;
    bit          m_xv;
    int          m_xp;
    job_t        m_x;
    int unsigned e_resp [NP];
    int unsigned e_data [NP];
    int unsigned e_tag  [NP];
    int          errs   = 0;
    int          checks = 0;
    bit          saw_full;

    task automatic chk(input string name, input int p, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s port%0d observed=%0h expected=%0h", name, p, obs, exp);
        end
    endtask

    // Reference arithmetic on wide unsigned integers.
    function automatic void ref_result(input job_t j, output int unsigned r, output int unsigned d);
        longint unsigned lim = 64'h1_0000_0000;
        longint unsigned sc  = 64'd1 << (j.b % 32);
        r = 2;
        d = 0;
        case (j.cmd)
            1: if (j.a + j.b < lim) begin r = 1; d = 32'(j.a + j.b); end
            2: if (j.b <= j.a)      begin r = 1; d = 32'(j.a - j.b); end
            5: begin r = 1; d = 32'((j.a * sc) % lim); end
            6: begin r = 1; d = 32'(j.a / sc); end
            default: ;
        endcase
    endfunction

    function automatic bit model_ready(input int p);
        return m_en && !m_pend[p] && (q[p].size() < D);
    endfunction

    task automatic tick();
        bit          rdy [NP];
        int          g;
        int unsigned r, d;
        job_t        j;
        for (int p = 0; p < NP; p++) rdy[p] = model_ready(p);
        @(posedge clk);
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                q[p].delete();
                m_pend[p] = 0;
                e_resp[p] = 0; e_data[p] = 0; e_tag[p] = 0;
            end
            m_en = 0; m_xv = 0; m_last = NP - 1;
        end else begin
            for (int p = 0; p < NP; p++) begin e_resp[p] = 0; e_data[p] = 0; e_tag[p] = 0; end
            if (m_xv) begin
                ref_result(m_x, r, d);
                e_resp[m_xp] = r; e_data[m_xp] = d; e_tag[m_xp] = m_x.tag;
            end
            g = -1;
            for (int i = 1; i <= NP; i++) begin
                int c;
                c = (m_last + i) % NP;
                if (g < 0 && q[c].size() > 0) g = c;
            end
            m_xv = (g >= 0);
            if (g >= 0) begin m_x = q[g].pop_front(); m_xp = g; m_last = g; end
            for (int p = 0; p < NP; p++) begin
                if (m_pend[p]) begin
                    j = m_cap[p];
                    j.b = req_data_in[p*DW +: DW];
                    q[p].push_back(j);
                    m_pend[p] = 0;
                end else if (req_cmd_in[p*4 +: 4] != 0 && rdy[p]) begin
                    m_pend[p]    = 1;
                    m_cap[p].cmd = req_cmd_in[p*4 +: 4];
                    m_cap[p].tag = req_tag_in[p*TW +: TW];
                    m_cap[p].a   = req_data_in[p*DW +: DW];
                end
            end
            m_en = 1;
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            chk("resp",  p, out_resp[p*2 +: 2],   e_resp[p]);
            chk("data",  p, out_data[p*DW +: DW], e_data[p]);
            chk("tag",   p, out_tag[p*TW +: TW],  e_tag[p]);
            chk("ready", p, req_ready[p],         model_ready(p));
        end
    endtask

    task automatic set_req(input int p, input int c, input int t, input logic [31:0] v);
        req_cmd_in[p*4 +: 4]   = 4'(c);
        req_tag_in[p*TW +: TW] = TW'(t);
        req_data_in[p*DW +: DW] = v;
    endtask

    task automatic clear_in();
        for (int p = 0; p < NP; p++) set_req(p, 0, 0, $urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin clear_in(); tick(); end
    endtask

    task automatic issue(input int p, input int c, input int t, input logic [31:0] a, input logic [31:0] b);
        clear_in(); set_req(p, c, t, a); tick();
        clear_in(); set_req(p, 0, 0, b); tick();
    endtask

    function automatic int rand_cmd();
        case ($urandom_range(0, 7))
            0, 1, 2: return 0;
            3:       return 1;
            4:       return 2;
            5:       return 5;
            6:       return 6;
            default: return $urandom_range(1, 15);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        clear_in();
        tick(); tick();
        chk("rst_ready", 0, req_ready, 0);
        chk("rst_resp",  0, out_resp, 0);
        reset = 1'b0;
        idle(1);
        chk("ready_after_rst", 0, req_ready, 4'hF);

        // single add on port 0
        issue(0, 1, 1, 32'h5, 32'h3);
        idle(2);
        chk("add_resp", 0, out_resp[1:0], 2'b01);
        chk("add_data", 0, out_data[31:0], 32'h8);
        chk("add_tag",  0, out_tag[1:0], 2'd1);
        idle(1);
        chk("add_clear", 0, {out_resp[1:0], out_data[31:0], out_tag[1:0]}, 0);

        // error and shift cases on port 1
        issue(1, 1, 2, 32'hFFFF_FFFF, 32'h1);
        idle(2);
        chk("ovf_resp", 1, out_resp[3:2], 2'b10);
        chk("ovf_data", 1, out_data[63:32], 0);
        issue(1, 2, 3, 32'h2, 32'h3);
        idle(2);
        chk("sub_resp", 1, out_resp[3:2], 2'b10);
        chk("sub_data", 1, out_data[63:32], 0);
        issue(1, 5, 0, 32'h1, 32'h21);
        idle(2);
        chk("shl_resp", 1, out_resp[3:2], 2'b01);
        chk("shl_data", 1, out_data[63:32], 32'h2);

        // unknown command on port 3
        issue(3, 15, 3, 32'h1234, 32'h5678);
        idle(2);
        chk("bad_resp", 3, out_resp[7:6], 2'b10);
        chk("bad_data", 3, out_data[127:96], 0);
        chk("bad_tag",  3, out_tag[7:6], 2'd3);

        // all ports at once: responses in port order on consecutive cycles
        clear_in();
        for (int p = 0; p < NP; p++) set_req(p, 1, p, 32'(p * 10));
        tick();
        clear_in();
        for (int p = 0; p < NP; p++) set_req(p, 0, 0, 32'h1);
        tick();
        idle(1);
        for (int p = 0; p < NP; p++) begin
            idle(1);
            chk("rr_resp", p, out_resp[p*2 +: 2], 2'b01);
            chk("rr_data", p, out_data[p*DW +: DW], 32'(p * 10 + 1));
        end
        idle(2);

        // saturate every port so port 2's FIFO fills and its ready drops
        saw_full = 0;
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < NP; p++) set_req(p, 1 + (i % 2), $urandom, $urandom_range(0, 100));
            tick();
            if (req_ready[2] == 1'b0 && m_en && !m_pend[2]) saw_full = 1;
        end
        chk("port2_backpressure", 2, saw_full, 1);
        idle(30);

        // reset one cycle after operand2: request must vanish
        issue(0, 1, 1, 32'h4, 32'h4);
        reset = 1'b1;
        clear_in(); tick();
        reset = 1'b0;
        idle(1);
        chk("ready_post_reset", 0, req_ready, 4'hF);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("no_resp_after_reset", 0, out_resp, 0);
        end

        // random traffic
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NP; p++)
                set_req(p, rand_cmd(), $urandom, ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 40));
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        idle(40);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/calc_engine_n.md
CALC_ENGINE_N -- requirements
Module: calc_engine_n

Interface
Parameters (name, default, meaning):
REQ-001 NUM_PORTS, 4, number of request/response ports (1..8).
REQ-002 DATA_W, 32, operand and result width.
REQ-003 TAG_W, 2, request tag width.
REQ-004 FIFO_DEPTH, 4, entries per port request FIFO (power of two, >=2).
Ports (name, direction, width, meaning):
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with the following ports:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- req_cmd_in, in, 4*NUM_PORTS, command per port.
- req_tag_in, in, TAG_W*NUM_PORTS, tag per port.
- req_data_in, in, DATA_W*NUM_PORTS, operand per port.
- req_ready, out, NUM_PORTS, port may issue a command this cycle.
- out_resp, out, 2*NUM_PORTS, response per port: 00 none, 01 success, 10 error.
- out_data, out, DATA_W*NUM_PORTS, result per port.
- out_tag, out, TAG_W*NUM_PORTS, echoed tag per port.

Function
REQ-006 A request on port p SHALL be a nonzero cmd sampled at edge k with req_ready[p]=1: cmd, tag and operand1 at edge k, operand2 on req_data_in at edge k+1; cmd at edge k+1 is ignored.
REQ-007 A nonzero cmd sampled while req_ready[p]=0 SHALL be discarded with no response and no state change.
REQ-008 Each port SHALL hold a FIFO of {cmd, tag, op1, op2}; the entry is written at edge k+1.
REQ-009 req_ready[p] SHALL be 1 iff (FIFO count + pending operand1 capture) < FIFO_DEPTH, and 0 during the operand2 cycle.
REQ-010 A round-robin arbiter SHALL grant one non-empty FIFO per cycle, searching from the port after the last grant; after reset the search starts at port 0.
REQ-011 The granted entry SHALL be popped and loaded into a single execute register at the grant edge; its result SHALL be registered to port p's outputs at the next edge.
REQ-012 Uncontended latency: op1 at edge k, grant at edge k+2, response visible after edge k+3.
REQ-013 A response SHALL be valid for exactly one cycle; out_resp, out_data and out_tag of a port SHALL return to 0 at the following edge unless a new result is loaded.
REQ-014 cmd 1 (add): op1+op2; a carry out of DATA_W SHALL give resp 10, data 0.
REQ-015 cmd 2 (sub): op1-op2; op2>op1 SHALL give resp 10, data 0.
REQ-016 cmd 5 (shift left) and cmd 6 (logical shift right): shift op1 by op2[log2(DATA_W)-1:0], resp 01; upper op2 bits are ignored.
REQ-017 Any other nonzero cmd SHALL give resp 10, data 0, tag echoed.
REQ-018 Responses on one port SHALL appear in that port's issue order; ordering across ports is arbiter-defined.
REQ-019 Simultaneous requests on all ports SHALL all be accepted if ready, with no loss or duplication.
REQ-020 A port SHALL accept back-to-back requests, with the next cmd at edge k+2.

Reset
REQ-021 While reset=1 at an edge, the block SHALL clear all FIFOs, pending captures, the execute register and the arbiter pointer, and drive all out_resp, out_data and out_tag to 0 and req_ready to 0.
REQ-022 At the first edge with reset=0, req_ready SHALL be all ones.
REQ-023 A reset asserted mid-operation SHALL discard in-flight requests with no response after reset deasserts.

Structure
REQ-024 A shared package SHALL hold the command encodings, response encodings and the FIFO-entry struct typedef.
REQ-025 The per-port FIFO SHALL be a separate sub-module, calc_req_fifo, instantiated NUM_PORTS times.

Verification
REQ-026 Port 0 issues add 0x0000_0005 + 0x0000_0003, tag 1 -> after edge k+3: out_resp[0]=01, out_data[0]=0x8, out_tag[0]=1, and 0 one cycle later.
REQ-027 Port 1 issues add 0xFFFF_FFFF + 0x1, then sub 0x2 - 0x3 -> both resp 10, data 0; shift left 0x1 by 0x21 -> data 0x2.
REQ-028 All 4 ports issue at the same edge -> four responses on consecutive cycles in order 0,1,2,3; the next round starts after the last grant.
REQ-029 Port 2 issues 5 back-to-back requests while the arbiter is held busy by ports 0, 1 and 3 -> req_ready[2] drops once FIFO_DEPTH entries are outstanding; the command issued while not ready gets no response; in-order responses follow.
REQ-030 Reset is asserted one cycle after operand2 of a pending request -> no response is ever produced; req_ready is all ones after reset.
REQ-031 cmd 0xF on port 3 -> resp 10, data 0, tag echoed.
